// File: rtl/sar_adc_scan_sequencer_if.sv
// sar_adc_scan_sequencer_if: scan sequencer control, SAR controller and result-port signals
interface sar_adc_scan_sequencer_if #(
  parameter int BITS = 8,
  parameter int NUM_CH = 4,
  parameter int CH_W = 2
);
  logic              enable;
  logic [NUM_CH-1:0] ch_mask;
  logic              adc_start;
  logic              adc_out_valid;
  logic [BITS-1:0]   adc_val;
  logic [CH_W-1:0]   mux_sel;
  logic              res_valid;
  logic              res_ready;
  logic [BITS-1:0]   res_data;
  logic [CH_W-1:0]   res_ch;
  logic              frame_done;
  logic              busy;
  logic              timeout_err;
  logic              err_clr;
  modport master (
    input  enable, ch_mask, adc_out_valid, adc_val, res_ready, err_clr,
    output adc_start, mux_sel, res_valid, res_data, res_ch, frame_done, busy, timeout_err
  );
  modport slave (
    output enable, ch_mask, adc_out_valid, adc_val, res_ready, err_clr,
    input  adc_start, mux_sel, res_valid, res_data, res_ch, frame_done, busy, timeout_err
  );
endinterface

// File: rtl/sar_adc_scan_sequencer.sv
// sar_adc_scan_sequencer: round-robin SAR ADC channel scanner with settling, timeout and result handshake
module sar_adc_scan_sequencer #(
  parameter int BITS = 8,
  parameter int NUM_CH = 4,
  parameter int CH_W = 2,
  parameter int SETTLE_CYCLES = 4,
  parameter int TIMEOUT_CYCLES = 32
) (
  input logic i_clk,
  input logic i_rst_n,
  sar_adc_scan_sequencer_if.master bus
);
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + SETTLE_CYCLES) + 1;
  typedef enum logic [2:0] {IDLE, SELECT, SETTLE, START, CONVERT, OUTPUT} state_t;
  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [CH_W-1:0]  r_last_ch, r_mux_sel, r_res_ch, r_hi_ch;
  logic [BITS-1:0]  r_res_data;
  logic             r_ov_q, r_adc_start, r_res_valid, r_frame_done, r_timeout_err;
  logic [CH_W-1:0]  w_first, w_after, w_top, w_next;
  logic             w_has_after, w_edge;
  // first set bit above last_ch, else lowest set bit (wrap); also the highest set bit for frame end
  always_comb begin
    w_first = '0;
    w_after = '0;
    w_has_after = 1'b0;
    w_top = '0;
    for (int i = NUM_CH - 1; i >= 0; i--)
      if (bus.ch_mask[i]) begin
        w_first = CH_W'(i);
        if (CH_W'(i) > r_last_ch) begin
          w_after = CH_W'(i);
          w_has_after = 1'b1;
        end
      end
    for (int i = 0; i < NUM_CH; i++)
      if (bus.ch_mask[i]) w_top = CH_W'(i);
    w_next = w_has_after ? w_after : w_first;
  end
  assign w_edge = bus.adc_out_valid & ~r_ov_q;
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_state <= IDLE;
      r_cnt <= '0;
      r_last_ch <= CH_W'(NUM_CH - 1);
      r_mux_sel <= '0;
      r_res_ch <= '0;
      r_hi_ch <= '0;
      r_res_data <= '0;
      r_ov_q <= 1'b0;
      r_adc_start <= 1'b0;
      r_res_valid <= 1'b0;
      r_frame_done <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      r_ov_q <= bus.adc_out_valid;
      r_adc_start <= 1'b0;
      r_frame_done <= 1'b0;
      if (bus.err_clr) r_timeout_err <= 1'b0;
      case (r_state)
        IDLE: if (bus.enable && |bus.ch_mask) r_state <= SELECT;
        SELECT:
          if (|bus.ch_mask) begin
            r_mux_sel <= w_next;
            r_hi_ch <= w_top;
            r_cnt <= '0;
            r_state <= SETTLE;
          end else r_state <= IDLE;
        SETTLE:
          if (r_cnt == CNT_W'(SETTLE_CYCLES - 1)) begin
            r_adc_start <= 1'b1;
            r_state <= START;
          end else r_cnt <= r_cnt + 1'b1;
        START: begin
          r_cnt <= '0;
          r_state <= CONVERT;
        end
        CONVERT:
          if (w_edge) begin
            r_res_data <= bus.adc_val;
            r_res_ch <= r_mux_sel;
            r_res_valid <= 1'b1;
            r_state <= OUTPUT;
          end else if (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            r_timeout_err <= 1'b1;
            r_last_ch <= r_mux_sel;
            r_state <= bus.enable ? SELECT : IDLE;
          end else r_cnt <= r_cnt + 1'b1;
        OUTPUT:
          if (bus.res_ready) begin
            r_res_valid <= 1'b0;
            r_last_ch <= r_res_ch;
            r_frame_done <= (r_res_ch == r_hi_ch);
            r_state <= bus.enable ? SELECT : IDLE;
          end
        default: r_state <= IDLE;
      endcase
    end
  assign bus.adc_start = r_adc_start;
  assign bus.mux_sel = r_mux_sel;
  assign bus.res_valid = r_res_valid;
  assign bus.res_data = r_res_data;
  assign bus.res_ch = r_res_ch;
  assign bus.frame_done = r_frame_done;
  assign bus.busy = (r_state != IDLE);
  assign bus.timeout_err = r_timeout_err;
endmodule

// File: tb/tb_sar_adc_scan_sequencer.sv
// tb_sar_adc_scan_sequencer: directed result table plus hand-written corner sequences
module tb_sar_adc_scan_sequencer;
  localparam int CONV = 11;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  sar_adc_scan_sequencer_if bus ();
  sar_adc_scan_sequencer dut (.i_clk(clk), .i_rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;

  // SAR controller stand-in: drops out_valid on start, raises it CONV+1 cycles later with 8'h10+ch
  logic [3:0] dead;
  logic       m_active;
  int         m_cnt;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      bus.adc_out_valid <= 1'b0;
      bus.adc_val <= '0;
      m_active <= 1'b0;
      m_cnt <= 0;
    end else if (bus.adc_start) begin
      bus.adc_out_valid <= 1'b0;
      bus.adc_val <= 8'h10 + 8'(bus.mux_sel);
      m_active <= !dead[bus.mux_sel];
      m_cnt <= CONV - 1;
    end else if (m_active) begin
      if (m_cnt == 0) begin
        bus.adc_out_valid <= 1'b1;
        m_active <= 1'b0;
      end else m_cnt <= m_cnt - 1;
    end

  int pass_cnt = 0;
  int total_cnt = 0;
  logic sparse_arm = 1'b0;
  int   bad_sel = 0;
  always @(negedge clk)
    if (sparse_arm && (bus.mux_sel == 2'd0 || bus.mux_sel == 2'd2)) bad_sel++;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  // waits for a result, optionally stalls it, then handshakes and checks frame_done
  task automatic get_result(input logic [1:0] ech, input logic [7:0] edata, input logic efd, input int stall);
    int n = 0;
    int bad = 0;
    logic [7:0] d0;
    logic [1:0] c0;
    while (!bus.res_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("res_valid_wait", 32'(n < 200), 1);
    check("res_ch", bus.res_ch, ech);
    check("res_data", bus.res_data, edata);
    d0 = bus.res_data;
    c0 = bus.res_ch;
    for (int k = 0; k < stall; k++) begin
      @(negedge clk);
      if (!bus.res_valid || bus.res_data != d0 || bus.res_ch != c0 || bus.adc_start) bad++;
    end
    if (stall > 0) check("stall_stable", bad, 0);
    bus.res_ready = 1'b1;
    @(negedge clk);
    bus.res_ready = 1'b0;
    check("frame_done", bus.frame_done, efd);
  endtask

  typedef struct {
    logic [3:0] mask;
    logic [1:0] ch;
    logic [7:0] data;
    logic       fd;
  } vec_t;
  vec_t vecs [9];

  initial begin
    int n;
    int k;
    int no_res;
    vecs[0] = '{4'b1111, 2'd0, 8'h10, 1'b0};
    vecs[1] = '{4'b1111, 2'd1, 8'h11, 1'b0};
    vecs[2] = '{4'b1111, 2'd2, 8'h12, 1'b0};
    vecs[3] = '{4'b1111, 2'd3, 8'h13, 1'b1};
    vecs[4] = '{4'b1111, 2'd0, 8'h10, 1'b0};
    vecs[5] = '{4'b1010, 2'd1, 8'h11, 1'b0};
    vecs[6] = '{4'b1010, 2'd3, 8'h13, 1'b1};
    vecs[7] = '{4'b1010, 2'd1, 8'h11, 1'b0};
    vecs[8] = '{4'b1010, 2'd3, 8'h13, 1'b1};
    dead = '0;
    bus.enable = 1'b0;
    bus.ch_mask = '0;
    bus.res_ready = 1'b0;
    bus.err_clr = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs", {bus.adc_start, bus.mux_sel, bus.res_valid, bus.res_data, bus.res_ch,
                            bus.frame_done, bus.busy, bus.timeout_err}, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_busy", bus.busy, 0);
    bus.enable = 1'b1;

    for (int i = 0; i < 9; i++) begin
      bus.ch_mask = vecs[i].mask;
      get_result(vecs[i].ch, vecs[i].data, vecs[i].fd, 0);
      if (i == 5) sparse_arm = 1'b1;
    end
    sparse_arm = 1'b0;
    check("sparse_mux_sel", bad_sel, 0);

    // backpressure on ch0, then ch1 selected the cycle after the handshake
    bus.ch_mask = 4'b1111;
    get_result(2'd0, 8'h10, 1'b0, 20);
    check("bp_sel_hold", bus.mux_sel, 0);
    @(negedge clk);
    check("bp_sel_next", bus.mux_sel, 1);
    repeat (3) @(negedge clk);
    check("settle_no_start", bus.adc_start, 0);
    @(negedge clk);
    check("settle_start", bus.adc_start, 1);
    get_result(2'd1, 8'h11, 1'b0, 0);

    // ch2 never completes: timeout after 32 CONVERT cycles, ch3 follows
    dead[2] = 1'b1;
    n = 0;
    while (!(bus.adc_start && bus.mux_sel == 2'd2) && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("to_start_wait", 32'(n < 50), 1);
    k = 0;
    no_res = 0;
    while (!bus.timeout_err && k < 100) begin
      @(negedge clk);
      k++;
      if (bus.res_valid) no_res++;
    end
    check("to_latency", k, 33);
    check("to_no_result", no_res, 0);
    get_result(2'd3, 8'h13, 1'b1, 0);
    check("to_sticky", bus.timeout_err, 1);
    dead[2] = 1'b0;
    bus.err_clr = 1'b1;
    @(negedge clk);
    bus.err_clr = 1'b0;
    check("err_clr", bus.timeout_err, 0);

    // enable drop during ch1 CONVERT
    get_result(2'd0, 8'h10, 1'b0, 0);
    n = 0;
    while (!(bus.adc_start && bus.mux_sel == 2'd1) && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("en_start_wait", 32'(n < 50), 1);
    repeat (3) @(negedge clk);
    bus.enable = 1'b0;
    get_result(2'd1, 8'h11, 1'b0, 0);
    check("en_idle_busy", bus.busy, 0);
    n = 0;
    repeat (5) begin
      @(negedge clk);
      if (bus.busy || bus.adc_start) n++;
    end
    check("en_stays_idle", n, 0);
    bus.enable = 1'b1;
    get_result(2'd2, 8'h12, 1'b0, 0);

    // reset during SETTLE of ch3
    @(negedge clk);
    check("pre_reset_sel", bus.mux_sel, 3);
    rst_n = 1'b0;
    #1;
    check("async_reset", {bus.adc_start, bus.mux_sel, bus.res_valid, bus.res_data, bus.res_ch,
                          bus.frame_done, bus.busy, bus.timeout_err}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    get_result(2'd0, 8'h10, 1'b0, 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/sar_adc_scan_sequencer.md
# sar_adc_scan_sequencer

Multi-channel scan scheduler for the 8-bit SAR ADC controller. Selects analog input channels round-robin from an enable mask, drives the analog mux select, waits a programmable settling time, and issues single-cycle `adc_start` pulses to the SAR controller. Captures each conversion result and presents it with its channel tag on a valid/ready result port. Flags conversions that never complete. Sits between the SAR ADC controller and the accelerator's sample-ingest logic.

## Interface
- `BITS`, 8: ADC result width; must match the SAR controller.
- `NUM_CH`, 4: number of analog channels (2..16).
- `CH_W`, 2: channel index width, equal to ceil(log2(NUM_CH)).
- `SETTLE_CYCLES`, 4: mux settling wait in cycles (>=1).
- `TIMEOUT_CYCLES`, 32: maximum wait for conversion completion in cycles (>= BITS+4).

- `clk` in 1: single clock; all logic is on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `enable` in 1: level; while high, scanning continues.
- `ch_mask` in NUM_CH: per-channel scan enable.
- `adc_start` out 1: one-cycle start pulse to the SAR controller.
- `adc_out_valid` in 1: SAR controller `out_valid` (level).
- `adc_val` in BITS: SAR controller result.
- `mux_sel` out CH_W: registered analog mux channel select.
- `res_valid` out 1: result available.
- `res_ready` in 1: consumer accepts the result.
- `res_data` out BITS: captured conversion result.
- `res_ch` out CH_W: channel of `res_data`.
- `frame_done` out 1: one-cycle pulse when the last enabled channel of a scan pass is accepted.
- `busy` out 1: high in any state other than IDLE.
- `timeout_err` out 1: sticky conversion-timeout flag.
- `err_clr` in 1: clears `timeout_err`.

## Operation
- Reset: all outputs are 0. `last_ch` is set to NUM_CH-1, so the first search starts at channel 0. The state is IDLE.
- States: IDLE, SELECT, SETTLE, START, CONVERT, OUTPUT.
- IDLE: if `enable`=1 and `ch_mask`!=0, go to SELECT. Otherwise stay in IDLE.
- SELECT, 1 cycle:
  - `ch_mask` is sampled only here.
  - The next channel is the first set mask bit strictly after `last_ch`, searching upward with wrap-around.
  - Register the channel into `mux_sel`, then go to SETTLE.
  - If the mask is now 0, go to IDLE instead.
- SETTLE: count SETTLE_CYCLES cycles, then go to START.
- START, 1 cycle: `adc_start`=1, then go to CONVERT. Clear the timeout counter.
- CONVERT:
  - Completion is a rising edge of `adc_out_valid`, detected against a registered copy. A level already high on entry to CONVERT is ignored.
  - On completion, capture `adc_val` into `res_data` and `mux_sel` into `res_ch`, then go to OUTPUT.
  - If the counter reaches TIMEOUT_CYCLES first: set `timeout_err`, emit no result, set `last_ch`=`mux_sel`, and go to SELECT if `enable`=1, otherwise IDLE.
- OUTPUT:
  - `res_valid`=1. `res_data` and `res_ch` are held stable until `res_ready`=1.
  - On handshake: set `last_ch`=`res_ch`. If `res_ch` is the highest set bit of the mask sampled in the last SELECT, pulse `frame_done`.
  - Next state is SELECT if `enable`=1, otherwise IDLE.
- Deasserting `enable` mid-scan does not abort the scan. The current conversion and its result handshake complete first, then the block returns to IDLE.
- `last_ch` persists across IDLE, so a resumed scan continues round-robin.
- `err_clr`: clears `timeout_err` on the next edge. If a timeout occurs in the same cycle, the set wins.
- Asynchronous reset mid-operation returns the block immediately to the reset state. Any pending result is discarded.

## Timing
- `mux_sel` changes at the end of the SELECT cycle.
- `adc_start` is high exactly SETTLE_CYCLES+1 cycles after SELECT is entered.
- `res_valid` rises 1 cycle after the cycle in which the `adc_out_valid` rising edge is detected.
- With `res_ready` held high, the SELECT after OUTPUT directly follows the handshake cycle.
- Per-channel period is 4+SETTLE_CYCLES+T_conv cycles, where T_conv is the number of cycles from `adc_start` to the detected edge.
- `frame_done` coincides with the handshake cycle, registered so it is high in the following cycle for 1 cycle.
- No combinational path runs from any input to `adc_start`, `mux_sel`, or `res_*`.

## Test plan
- Basic scan:
  - Stimulus: `ch_mask`=4'b1111, model with 12-cycle conversions returning 8'h10+ch, `res_ready`=1.
  - Required: results in order ch0..ch3 with data 8'h10..8'h13, `frame_done` after ch3, then wrap back to ch0.
- Sparse mask:
  - Stimulus: `ch_mask`=4'b1010.
  - Required: channel order 1,3,1,3; `frame_done` after each ch3; `mux_sel` never 0 or 2.
- Backpressure:
  - Stimulus: `res_ready`=0 for 20 cycles on the ch0 result.
  - Required: `res_valid`, `res_data`, and `res_ch`=0 held stable; no `adc_start` pulse during the stall; ch1 is selected 1 cycle after `res_ready` rises.
- Timeout:
  - Stimulus: model never raises `out_valid` for ch2.
  - Required: `timeout_err`=1 after 32 CONVERT cycles, no ch2 result, ch3 converts next. Then `err_clr` pulse gives `timeout_err`=0.
- Enable drop mid-conversion:
  - Stimulus: `enable`=0 during the ch1 CONVERT.
  - Required: the ch1 result is still delivered, then IDLE with `busy`=0. Re-enabling resumes at ch2.
- Reset mid-SETTLE:
  - Stimulus: `rst_n` pulse during SETTLE.
  - Required: all outputs 0 immediately; the next scan starts at ch0.
